// File: rtl/cpu_pkg.sv
// cpu_pkg: shared encodings for the 16-bit core control path (sequencer FSM states,
// decode-word bit positions, address and write-back mux selects).
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_IMM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } state_e;

  localparam int CTRL_LDI      = 0;
  localparam int CTRL_MEM_RD   = 1;
  localparam int CTRL_MEM_WR   = 2;
  localparam int CTRL_SAVE_PC  = 3;
  localparam int CTRL_WRITE_PC = 4;
  localparam int CTRL_PC_REL   = 5;
  localparam int CTRL_IMM      = 6;
  localparam int CTRL_COND     = 7;
  localparam int CTRL_BYTE     = 8;
  localparam int CTRL_LUI      = 9;
  localparam int CTRL_SCR      = 10;

  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_ALU = 2'd1;
  localparam logic [1:0] ADDR_IMM = 2'd2;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_LINK = 2'd2;
  localparam logic [1:0] WB_IMM  = 2'd3;

endpackage

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute FSM with registered (Moore) strobes.
// Define CPU_SEQUENCER_TIMEOUT_EN to add a memory-wait watchdog that parks the FSM in FAULT.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int          CTRL_W      = 16,
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CTRL_W-1:0] ctrl_flags,
  input  logic              alu_zero,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        addr_sel,
  output logic              ir_load,
  output logic              imm_load,
  output logic              pc_inc,
  output logic              pc_write,
  output logic              reg_we,
  output logic [1:0]        wb_sel,
  output logic [2:0]        state_o,
  output logic              fault
);

  state_e            state_r, next_state_s;
  logic [CTRL_W-1:0] flags_r;
  logic              ack_s, timeout_s;
  logic              ir_load_s, imm_load_s, pc_inc_s, pc_write_s;
  logic [1:0]        wb_src_s;
  logic              mem_req_s, mem_we_s, reg_we_s;
  logic [1:0]        addr_sel_s, wb_sel_s;
  logic              mem_req_r, mem_we_r, ir_load_r, imm_load_r, pc_inc_r, pc_write_r, reg_we_r;
  logic [1:0]        addr_sel_r, wb_sel_r;
  logic              unused_s;

  // An ack only counts while our own request is visible on the port.
  assign ack_s = mem_ack & mem_req_r;

  // Next state and transition strobes; the decode word is read live only in DECODE.
  always_comb begin
    next_state_s = state_r;
    ir_load_s    = 1'b0;
    imm_load_s   = 1'b0;
    pc_inc_s     = 1'b0;
    pc_write_s   = 1'b0;
    wb_src_s     = WB_ALU;
    case (state_r)
      ST_FETCH: begin
        if (ack_s) begin
          ir_load_s    = 1'b1;
          pc_inc_s     = 1'b1;
          next_state_s = ST_DECODE;
        end else if (timeout_s) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (ctrl_flags[CTRL_LDI] | ctrl_flags[CTRL_IMM]) begin
          next_state_s = ST_IMM;
        end else begin
          next_state_s = ST_EXEC;
        end
      end
      ST_IMM: begin
        if (ack_s) begin
          imm_load_s   = 1'b1;
          pc_inc_s     = 1'b1;
          next_state_s = ST_EXEC;
        end else if (timeout_s) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_IMM;
        end
      end
      ST_EXEC: begin
        if (flags_r[CTRL_COND]) begin
          pc_write_s   = alu_zero;
          next_state_s = ST_FETCH;
        end else if (flags_r[CTRL_WRITE_PC]) begin
          pc_write_s = 1'b1;
          if (flags_r[CTRL_SAVE_PC]) begin
            wb_src_s     = WB_LINK;
            next_state_s = ST_WB;
          end else begin
            next_state_s = ST_FETCH;
          end
        end else if (flags_r[CTRL_MEM_RD] | flags_r[CTRL_MEM_WR]) begin
          next_state_s = ST_MEM;
        end else begin
          next_state_s = ST_WB;
        end
      end
      ST_MEM: begin
        // A word with both RD and WR set is handled as a store.
        if (ack_s) begin
          if (flags_r[CTRL_MEM_WR]) begin
            next_state_s = ST_FETCH;
          end else begin
            wb_src_s     = WB_MEM;
            next_state_s = ST_WB;
          end
        end else if (timeout_s) begin
          next_state_s = ST_FAULT;
        end else begin
          next_state_s = ST_MEM;
        end
      end
      ST_WB: next_state_s = ST_FETCH;
      ST_FAULT: begin
`ifdef CPU_SEQUENCER_TIMEOUT_EN
        next_state_s = ST_FAULT;
`else
        next_state_s = ST_FETCH;
`endif
      end
      default: next_state_s = ST_FETCH;
    endcase
  end

  // Level outputs for the coming cycle, decoded from the state being entered.
  always_comb begin
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    addr_sel_s = ADDR_PC;
    reg_we_s   = 1'b0;
    wb_sel_s   = WB_ALU;
    case (next_state_s)
      ST_FETCH: mem_req_s = 1'b1;
      ST_IMM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = ADDR_IMM;
      end
      ST_MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = ADDR_ALU;
        mem_we_s   = flags_r[CTRL_MEM_WR];
      end
      ST_WB: begin
        reg_we_s = 1'b1;
        if (flags_r[CTRL_LDI] | flags_r[CTRL_LUI]) begin
          wb_sel_s = WB_IMM;
        end else begin
          wb_sel_s = wb_src_s;
        end
      end
      default: mem_req_s = 1'b0;
    endcase
  end

  // State, held decode word and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_FETCH;
      flags_r    <= {CTRL_W{1'b0}};
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      addr_sel_r <= ADDR_PC;
      ir_load_r  <= 1'b0;
      imm_load_r <= 1'b0;
      pc_inc_r   <= 1'b0;
      pc_write_r <= 1'b0;
      reg_we_r   <= 1'b0;
      wb_sel_r   <= WB_ALU;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_DECODE) begin
        flags_r <= ctrl_flags;
      end
      mem_req_r  <= mem_req_s;
      mem_we_r   <= mem_we_s;
      addr_sel_r <= addr_sel_s;
      ir_load_r  <= ir_load_s;
      imm_load_r <= imm_load_s;
      pc_inc_r   <= pc_inc_s;
      pc_write_r <= pc_write_s;
      reg_we_r   <= reg_we_s;
      wb_sel_r   <= wb_sel_s;
    end
  end

`ifdef CPU_SEQUENCER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] wait_cnt_r;
  logic       fault_r;

  assign timeout_s = mem_req_r & ~ack_s & ((wait_cnt_r + 8'd1) == TIMEOUT_LIM);

  // Wait counter restarts on every state entry and counts unacknowledged request cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
      fault_r    <= 1'b0;
    end else begin
      fault_r <= (next_state_s == ST_FAULT);
      if (next_state_s != state_r) begin
        wait_cnt_r <= 8'd0;
      end else if (mem_req_r & ~ack_s) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
    end
  end

  assign fault = fault_r;
`else
  assign timeout_s = 1'b0;
  assign fault     = 1'b0;
`endif

  // RESET_PC belongs to the datapath PC register; unused decode bits are for the datapath too.
  assign unused_s = ^{RESET_PC, flags_r, 32'(TIMEOUT_CYC)};

  assign mem_req  = mem_req_r;
  assign mem_we   = mem_we_r;
  assign addr_sel = addr_sel_r;
  assign ir_load  = ir_load_r;
  assign imm_load = imm_load_r;
  assign pc_inc   = pc_inc_r;
  assign pc_write = pc_write_r;
  assign reg_we   = reg_we_r;
  assign wb_sel   = wb_sel_r;
  assign state_o  = state_r;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: table-driven scoreboard bench; every cycle's expected output vector is
// queued as the stimulus is driven and compared one step later, #1 after the clock edge.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ctrl_flags = 16'h0000;
  logic        alu_zero = 1'b0;
  logic        mem_ack = 1'b0;
  logic        mem_req, mem_we, ir_load, imm_load, pc_inc, pc_write, reg_we, fault;
  logic [1:0]  addr_sel, wb_sel;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  cpu_sequencer #(.CTRL_W(16), .RESET_PC(16'h0000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .ctrl_flags(ctrl_flags), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
    .imm_load(imm_load), .pc_inc(pc_inc), .pc_write(pc_write), .reg_we(reg_we),
    .wb_sel(wb_sel), .state_o(state_o), .fault(fault)
  );

  // {state, fault, req, we, addr_sel, ir_load, imm_load, pc_inc, pc_write, reg_we, wb_sel}
  logic [14:0] obs;
  assign obs = {state_o, fault, mem_req, mem_we, addr_sel, ir_load, imm_load, pc_inc,
                pc_write, reg_we, wb_sel};

  localparam logic [14:0] VZ     = {3'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VF     = {3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VF_PCW = {3'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
  localparam logic [14:0] VD     = {3'd1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VI     = {3'd2, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VE     = {3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VE_IMM = {3'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VM_RD  = {3'd4, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VM_WR  = {3'd4, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
  localparam logic [14:0] VW_ALU = {3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0};
  localparam logic [14:0] VW_MEM = {3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
  localparam logic [14:0] VW_LNK = {3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2};
  localparam logic [14:0] VW_IMM = {3'd5, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3};
  localparam logic [14:0] VFAULT = {3'd6, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

  typedef struct {
    logic        rst;
    logic        ack;
    logic        zero;
    logic [15:0] ctrl;
    logic [14:0] exp;
  } step_t;

  logic [14:0] expq[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic drive(input step_t s);
    expq.push_back(s.exp);
    rst = s.rst;
    mem_ack = s.ack;
    alu_zero = s.zero;
    ctrl_flags = s.ctrl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t t[11];
    logic [14:0] e;
    t = '{'{1'b1, 1'b1, 1'b0, 16'h0000, VZ}, '{1'b1, 1'b0, 1'b0, 16'h0000, VZ},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VF}, '{1'b0, 1'b1, 1'b0, 16'h0000, VD},
          '{1'b0, 1'b0, 1'b0, 16'h0102, VE}, '{1'b0, 1'b0, 1'b0, 16'h0102, VM_RD},
          '{1'b0, 1'b0, 1'b0, 16'h0102, VM_RD}, '{1'b1, 1'b1, 1'b0, 16'h0102, VZ},
          '{1'b1, 1'b1, 1'b0, 16'h0102, VZ}, '{1'b1, 1'b1, 1'b0, 16'h0102, VZ},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VF}};
    for (int i = 0; i < 11; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_alu_op();
    step_t t[4];
    logic [14:0] e;
    t = '{'{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0000, VE},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VW_ALU}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF}};
    for (int i = 0; i < 4; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL alu_op[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  // Decode word changes to a branch after DECODE; the held load word must still win.
  task automatic test_load();
    step_t t[8];
    logic [14:0] e;
    t = '{'{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0102, VE},
          '{1'b0, 1'b1, 1'b0, 16'h0090, VM_RD}, '{1'b0, 1'b0, 1'b0, 16'h0090, VM_RD},
          '{1'b0, 1'b0, 1'b0, 16'h0090, VM_RD}, '{1'b0, 1'b0, 1'b0, 16'h0090, VM_RD},
          '{1'b0, 1'b1, 1'b0, 16'h0090, VW_MEM}, '{1'b0, 1'b1, 1'b0, 16'h0090, VF}};
    for (int i = 0; i < 8; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL load[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_branch();
    step_t t[7];
    logic [14:0] e;
    t = '{'{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h00B0, VE},
          '{1'b0, 1'b0, 1'b1, 16'h00B0, VF_PCW}, '{1'b0, 1'b0, 1'b1, 16'h0000, VF},
          '{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h00B0, VE},
          '{1'b0, 1'b0, 1'b0, 16'h00B0, VF}};
    for (int i = 0; i < 7; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL branch[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_ldi();
    step_t t[6];
    logic [14:0] e;
    t = '{'{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0001, VI},
          '{1'b0, 1'b0, 1'b0, 16'h0001, VI}, '{1'b0, 1'b1, 1'b0, 16'h0001, VE_IMM},
          '{1'b0, 1'b0, 1'b0, 16'h0001, VW_IMM}, '{1'b0, 1'b0, 1'b0, 16'h0001, VF}};
    for (int i = 0; i < 6; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL ldi[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  // Store, RD+WR (store wins), jump-and-link, LUI.
  task automatic test_store_jal_lui();
    step_t t[16];
    logic [14:0] e;
    t = '{'{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0004, VE},
          '{1'b0, 1'b0, 1'b0, 16'h0004, VM_WR}, '{1'b0, 1'b1, 1'b0, 16'h0004, VF},
          '{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0006, VE},
          '{1'b0, 1'b0, 1'b0, 16'h0006, VM_WR}, '{1'b0, 1'b1, 1'b0, 16'h0006, VF},
          '{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0018, VE},
          '{1'b0, 1'b0, 1'b0, 16'h0018, VW_LNK}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF},
          '{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b0, 1'b0, 16'h0200, VE},
          '{1'b0, 1'b0, 1'b0, 16'h0200, VW_IMM}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF}};
    for (int i = 0; i < 16; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL store_jal_lui[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  // ack held high throughout: only FETCH may consume it.
  task automatic test_back_to_back();
    step_t s;
    logic [14:0] e;
    logic [14:0] seq[4];
    seq = '{VD, VE, VW_ALU, VF};
    for (int i = 0; i < 12; i++) begin
      s = '{1'b0, 1'b1, 1'b0, 16'h0000, seq[i % 4]};
      drive(s);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    step_t t[10];
    logic [14:0] e;
`ifdef CPU_SEQUENCER_TIMEOUT_EN
    t = '{'{1'b1, 1'b0, 1'b0, 16'h0000, VZ}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VF}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VF}, '{1'b0, 1'b0, 1'b0, 16'h0000, VFAULT},
          '{1'b0, 1'b1, 1'b0, 16'h0000, VFAULT}, '{1'b0, 1'b1, 1'b0, 16'h0000, VFAULT},
          '{1'b1, 1'b0, 1'b0, 16'h0000, VZ}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF}};
`else
    t = '{'{1'b1, 1'b0, 1'b0, 16'h0000, VZ}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VF}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF},
          '{1'b0, 1'b0, 1'b0, 16'h0000, VF}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF},
          '{1'b0, 1'b1, 1'b0, 16'h0000, VD}, '{1'b0, 1'b1, 1'b0, 16'h0000, VE},
          '{1'b1, 1'b0, 1'b0, 16'h0000, VZ}, '{1'b0, 1'b0, 1'b0, 16'h0000, VF}};
`endif
    for (int i = 0; i < 10; i++) begin
      drive(t[i]);
      e = expq.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL timeout[%0d]: dut=%h expected=%h", i, obs, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_branch();
    test_ldi();
    test_store_jal_lui();
    test_back_to_back();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle control FSM that drives the fetch/decode/execute loop of the 16-bit core.
- Takes the per-opcode decode word from the instruction decode ROM and the ALU zero flag.
- Produces one-hot-per-cycle strobes for IR, PC, the register file and the shared memory port.
- Owns the single memory request/ack handshake. Instruction fetch, immediate fetch and data load/store are serialised through it.

Parameters:
- CTRL_W, 16, width of decode control word
- RESET_PC, 16'h0000, PC value loaded on reset
- TIMEOUT_CYC, 255, memory-wait limit in cycles (used only with optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- ctrl_flags  in  CTRL_W  decode word. Bit meanings: [0] LDI, [1] MEM_RD, [2] MEM_WR, [3] SAVE_PC, [4] WRITE_PC, [5] PC_REL, [6] IMM, [7] COND, [8] BYTE, [9] LUI, [10] SCR
- alu_zero  in  1  ALU result zero, valid in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  write qualifier for mem_req
- addr_sel  out  2  0 = PC, 1 = ALU result, 2 = PC+1 (immediate)
- ir_load  out  1  latch instruction word
- imm_load  out  1  latch immediate word
- pc_inc  out  1  PC <= PC+1
- pc_write  out  1  PC <= target
- reg_we  out  1  register-file write
- wb_sel  out  2  0 = ALU, 1 = memory, 2 = PC (link), 3 = immediate
- state_o  out  3  current state, debug
- fault  out  1  sticky fault (optional feature)

Behaviour:
- States: FETCH=0, DECODE=1, IMM=2, EXEC=3, MEM=4, WB=5, FAULT=6.
- Reset: state=FETCH; all outputs 0; fault=0. Reset wins over every event, including mid-handshake. mem_req drops on the cycle after rst is sampled.
- Outputs are registered (Moore). Strobes are single-cycle pulses.

FETCH:
- mem_req=1, mem_we=0, addr_sel=0.
- On mem_ack: ir_load=1, pc_inc=1, go to DECODE.
- No ack: stay, keep request asserted.

DECODE (1 cycle):
- LDI or IMM set -> IMM.
- Otherwise -> EXEC.

IMM:
- mem_req=1, addr_sel=2.
- On ack: imm_load=1, pc_inc=1, go to EXEC.

EXEC (1 cycle):
- COND set: pc_write=1 iff alu_zero=1, then -> FETCH.
- WRITE_PC set: pc_write=1. If SAVE_PC is also set, go to WB with wb_sel=2. Otherwise -> FETCH.
- MEM_RD or MEM_WR -> MEM.
- Otherwise -> WB.

MEM:
- mem_req=1, addr_sel=1, mem_we=MEM_WR.
- On ack: MEM_RD goes to WB with wb_sel=1; MEM_WR goes to FETCH.
- MEM_RD and MEM_WR both set: treated as write.

WB (1 cycle):
- reg_we=1.
- wb_sel: LDI or LUI -> 3; else as set on entry; else 0.
- Then -> FETCH.

General timing:
- ctrl_flags is sampled once in DECODE and held internally. Later changes on the input are ignored until the next DECODE.
- Minimum latency:
  - ALU op: 4 cycles (FETCH with 0-wait ack, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Untaken branch: 3 cycles.
- mem_ack outside FETCH/IMM/MEM is ignored.

Optional Feature:
- Macro: CPU_SEQUENCER_TIMEOUT_EN.
- With the macro: an 8-bit wait counter clears on each entry to FETCH/IMM/MEM and increments every cycle without ack. When it reaches TIMEOUT_CYC, the FSM goes to FAULT: mem_req=0, fault=1, all strobes 0, stays there until rst.
- Without the macro: no counter, FAULT unreachable, fault tied 0.

Decomposition:
- Package cpu_pkg holds:
  - state enum
  - ctrl bit-index constants (CTRL_LDI ... CTRL_SCR)
  - addr_sel and wb_sel encodings
- The decode ROM and this block both import cpu_pkg.
- No sub-module needed. The timeout counter stays inline under the macro.

Test Plan:
- rst held 3 cycles mid-MEM with mem_req=1 -> the cycle after release shows state=FETCH, mem_req=1, addr_sel=0, and all other outputs 0.
- ALU op (ctrl=0), ack immediate -> ir_load at cycle 1, reg_we with wb_sel=0 at cycle 4, back in FETCH at cycle 5.
- Load (ctrl=0x102), data ack after 3 wait cycles -> mem_req stays high 4 cycles, then reg_we with wb_sel=1, with no mem_we.
- Branch (ctrl=0xB0): alu_zero=1 -> pc_write pulse then FETCH. alu_zero=0 -> no pc_write.
- LDI (ctrl=0x01) -> two fetches, PC incremented twice, imm_load once, then reg_we with wb_sel=3.
- With CPU_SEQUENCER_TIMEOUT_EN and TIMEOUT_CYC=4, no ack in FETCH -> fault=1 and mem_req=0 after 4 cycles. Fault holds until rst.
